// File: rtl/riscv_pkg.sv
// Shared constants for the RISC-V pipeline front end: control-bundle layout,
// NOP encoding and the default reset PC.
package riscv_pkg;

    localparam int unsigned CTRL_WIDTH = 10;

    // Bit positions inside the packed decode control bundle (MSB first)
    localparam int unsigned CTRL_REG_WR_EN      = 9;
    localparam int unsigned CTRL_RESULT_SRC_MSB = 8;
    localparam int unsigned CTRL_RESULT_SRC_LSB = 7;
    localparam int unsigned CTRL_MEM_WR_EN      = 6;
    localparam int unsigned CTRL_JUMP           = 5;
    localparam int unsigned CTRL_BRANCH         = 4;
    localparam int unsigned CTRL_ALU_CTRL_MSB   = 3;
    localparam int unsigned CTRL_ALU_CTRL_LSB   = 1;
    localparam int unsigned CTRL_ALU_SRC        = 0;

    typedef enum logic [1:0] {
        RESULT_ALU  = 2'd0,
        RESULT_MEM  = 2'd1,
        RESULT_PC4  = 2'd2
    } result_src_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/riscv_pipe_reg.sv
// Generic pipeline register: synchronous reset value, flush value and stall
// hold, with reset > flush > stall > load priority.
module riscv_pipe_reg #(
    parameter int unsigned W         = 32,
    parameter logic [W-1:0] RST_VAL   = '0,
    parameter logic [W-1:0] FLUSH_VAL = '0
) (
    input  logic         iclk,
    input  logic         irst_n,
    input  logic         iflush,
    input  logic         istall,
    input  logic [W-1:0] id,
    output logic [W-1:0] oq
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = id;
        if (iflush) begin
            data_d = FLUSH_VAL;
        end else if (istall) begin
            data_d = data_q;
        end
    end

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign oq = data_q;

endmodule

// File: rtl/riscv_pipe_front_regs.sv
// PC, IF/ID and ID/EX pipeline registers with hazard-unit stall/flush controls
// and saturating stall/flush event counters.
module riscv_pipe_front_regs
    import riscv_pkg::*;
#(
    parameter int unsigned MP_XLEN               = 32,
    parameter int unsigned MP_REGFILE_ADDR_WIDTH = 5,
    parameter int unsigned MP_CTRL_WIDTH         = CTRL_WIDTH,
    parameter logic [MP_XLEN-1:0] MP_RESET_PC    = MP_XLEN'(RESET_PC),
    parameter int unsigned MP_CNT_WIDTH          = 16
) (
    input  logic                             iclk,
    input  logic                             irst_n,
    input  logic                             istall_f,
    input  logic                             istall_d,
    input  logic                             iflush_d,
    input  logic                             iflush_e,
    input  logic [MP_XLEN-1:0]               ipc_next,
    input  logic [31:0]                      iinstr_f,
    input  logic [MP_CTRL_WIDTH-1:0]         icontrol_d,
    input  logic [MP_REGFILE_ADDR_WIDTH-1:0] irs1_d,
    input  logic [MP_REGFILE_ADDR_WIDTH-1:0] irs2_d,
    input  logic [MP_REGFILE_ADDR_WIDTH-1:0] ird_d,
    input  logic [MP_XLEN-1:0]               irs1_data_d,
    input  logic [MP_XLEN-1:0]               irs2_data_d,
    input  logic [MP_XLEN-1:0]               iimm_d,
    output logic [MP_XLEN-1:0]               opc_f,
    output logic [MP_XLEN-1:0]               opc_d,
    output logic [MP_XLEN-1:0]               opc_plus4_d,
    output logic [31:0]                      oinstr_d,
    output logic                             ovalid_d,
    output logic                             ovalid_e,
    output logic [MP_CTRL_WIDTH-1:0]         ocontrol_e,
    output logic [MP_REGFILE_ADDR_WIDTH-1:0] ors1_1d,
    output logic [MP_REGFILE_ADDR_WIDTH-1:0] ors2_1d,
    output logic [MP_REGFILE_ADDR_WIDTH-1:0] ord_1d,
    output logic [MP_XLEN-1:0]               ors1_data_e,
    output logic [MP_XLEN-1:0]               ors2_data_e,
    output logic [MP_XLEN-1:0]               oimm_e,
    output logic [MP_XLEN-1:0]               opc_e,
    output logic [MP_XLEN-1:0]               opc_plus4_e,
    output logic [MP_CNT_WIDTH-1:0]          ostall_cnt,
    output logic [MP_CNT_WIDTH-1:0]          oflush_cnt
);

    localparam int unsigned IFID_W = 32 + 1 + 2 * MP_XLEN;
    localparam int unsigned IDEX_W = MP_CTRL_WIDTH + 3 * MP_REGFILE_ADDR_WIDTH + 5 * MP_XLEN + 1;

    // IF/ID bubble: NOP, invalid, both PCs zero; identical for reset and flush
    localparam logic [IFID_W-1:0] IFID_BUBBLE = {NOP_INSTR, 1'b0, {(2 * MP_XLEN){1'b0}}};

    logic [MP_XLEN-1:0] pc_plus4_f;
    logic [IFID_W-1:0]  ifid_d;
    logic [IFID_W-1:0]  ifid_q;
    logic [IDEX_W-1:0]  idex_d;
    logic [IDEX_W-1:0]  idex_q;

    assign pc_plus4_f = opc_f + MP_XLEN'(4);

    riscv_pipe_reg #(
        .W         (MP_XLEN),
        .RST_VAL   (MP_RESET_PC),
        .FLUSH_VAL ('0)
    ) u_pc_reg (
        .iclk   (iclk),
        .irst_n (irst_n),
        .iflush (1'b0),
        .istall (istall_f),
        .id     (ipc_next),
        .oq     (opc_f)
    );

    assign ifid_d = {iinstr_f, 1'b1, opc_f, pc_plus4_f};

    riscv_pipe_reg #(
        .W         (IFID_W),
        .RST_VAL   (IFID_BUBBLE),
        .FLUSH_VAL (IFID_BUBBLE)
    ) u_ifid_reg (
        .iclk   (iclk),
        .irst_n (irst_n),
        .iflush (iflush_d),
        .istall (istall_d),
        .id     (ifid_d),
        .oq     (ifid_q)
    );

    assign {oinstr_d, ovalid_d, opc_d, opc_plus4_d} = ifid_q;

    assign idex_d = {icontrol_d, irs1_d, irs2_d, ird_d,
                     irs1_data_d, irs2_data_d, iimm_d, opc_d, opc_plus4_d, ovalid_d};

    riscv_pipe_reg #(
        .W         (IDEX_W),
        .RST_VAL   ('0),
        .FLUSH_VAL ('0)
    ) u_idex_reg (
        .iclk   (iclk),
        .irst_n (irst_n),
        .iflush (iflush_e),
        .istall (1'b0),
        .id     (idex_d),
        .oq     (idex_q)
    );

    assign {ocontrol_e, ors1_1d, ors2_1d, ord_1d,
            ors1_data_e, ors2_data_e, oimm_e, opc_e, opc_plus4_e, ovalid_e} = idex_q;

    logic [MP_CNT_WIDTH-1:0] stall_cnt_d;
    logic [MP_CNT_WIDTH-1:0] stall_cnt_q;
    logic [MP_CNT_WIDTH-1:0] flush_cnt_d;
    logic [MP_CNT_WIDTH-1:0] flush_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((istall_f | istall_d) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + MP_CNT_WIDTH'(1);
        end
        if ((iflush_d | iflush_e) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + MP_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ostall_cnt = stall_cnt_q;
    assign oflush_cnt = flush_cnt_q;

endmodule
